// File: rtl/ahb_gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO with interrupts: register word offsets,
// interrupt encodings and parameter limits.
package ahb_gpio_pkg;

   // Register offsets as word indices (HADDR[5:2]); byte offset = index * 4
   localparam logic [3:0] REG_OUT   = 4'h0;
   localparam logic [3:0] REG_DIR   = 4'h1;
   localparam logic [3:0] REG_IN    = 4'h2;
   localparam logic [3:0] REG_IE    = 4'h3;
   localparam logic [3:0] REG_ITYPE = 4'h4;
   localparam logic [3:0] REG_IPOL  = 4'h5;
   localparam logic [3:0] REG_ISTAT = 4'h6;
   localparam logic [3:0] REG_SET   = 4'h7;
   localparam logic [3:0] REG_CLR   = 4'h8;
   localparam logic [3:0] REG_TGL   = 4'h9;

   localparam logic ITYPE_LEVEL = 1'b0;
   localparam logic ITYPE_EDGE  = 1'b1;
   localparam logic IPOL_LOW    = 1'b0;
   localparam logic IPOL_HIGH   = 1'b1;

   localparam int WIDTH_MIN       = 1;
   localparam int WIDTH_MAX       = 32;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/ahb_gpio_irq_sync.sv
// Multi-bit input synchroniser: a STAGES-deep chain of reset-to-0 flops per pin.
module gpio_sync #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO with per-bit direction, synchronised inputs and edge/level interrupts.
// Define AHB_GPIO_SETCLR_EN to add the SET/CLR/TGL write-only aliases of OUT.
module ahb_gpio_irq
   import ahb_gpio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             HSEL,
   input  logic [7:0]       HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic             HREADY,
   input  logic [31:0]      HWDATA,
   output logic [31:0]      HRDATA,
   output logic             HREADYOUT,
   output logic             HRESP,
   inout  wire  [WIDTH-1:0] pins,
   output logic             irq
);

   logic             dpValid, dpWrite;
   logic [3:0]       dpAddr;
   logic [WIDTH-1:0] outReg, dirReg, ieReg, itypeReg, ipolReg, istatReg;
   logic [WIDTH-1:0] syncQ, prevQ, eventBits, clrBits, rdata, wdata;
   logic             wrEn, unusedBits;

   assign HREADYOUT  = 1'b1;
   assign HRESP      = 1'b0;
   assign wdata      = HWDATA[WIDTH-1:0];
   assign wrEn       = dpValid && dpWrite;
   assign unusedBits = ^{HADDR[7:6], HADDR[1:0], HTRANS[0], HWDATA};

   for (genvar i = 0; i < WIDTH; i++) begin : gPad
      assign pins[i] = dirReg[i] ? outReg[i] : 1'bz;
   end

   gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) uSync (
      .clock (HCLK),
      .reset (HRESET),
      .d     (pins),
      .q     (syncQ)
   );

   // Address phase is captured here; the data phase acts on these registered fields
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dpValid <= 1'b0;
         dpWrite <= 1'b0;
         dpAddr  <= '0;
      end else begin
         dpValid <= HSEL && HREADY && HTRANS[1];
         dpWrite <= HWRITE;
         dpAddr  <= HADDR[5:2];
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         outReg   <= '0;
         dirReg   <= '0;
         ieReg    <= '0;
         itypeReg <= '0;
         ipolReg  <= '0;
      end else if (wrEn) begin
         case (dpAddr)
            REG_OUT:   outReg   <= wdata;
            REG_DIR:   dirReg   <= wdata;
            REG_IE:    ieReg    <= wdata;
            REG_ITYPE: itypeReg <= wdata;
            REG_IPOL:  ipolReg  <= wdata;
`ifdef AHB_GPIO_SETCLR_EN
            REG_SET:   outReg   <= outReg | wdata;
            REG_CLR:   outReg   <= outReg & ~wdata;
            REG_TGL:   outReg   <= outReg ^ wdata;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      eventBits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (itypeReg[i] == ITYPE_EDGE)
            eventBits[i] = (syncQ[i] != prevQ[i]) && (syncQ[i] == ipolReg[i]);
         else
            eventBits[i] = (syncQ[i] == ipolReg[i]);
      end
   end

   assign clrBits = (wrEn && dpAddr == REG_ISTAT) ? wdata : '0;

   // OR-ing the set term last lets a still-active source win over a same-cycle W1C
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         prevQ    <= '0;
         istatReg <= '0;
      end else begin
         prevQ    <= syncQ;
         istatReg <= (istatReg & ~clrBits) | (eventBits & ieReg);
      end
   end

   assign irq = |(istatReg & ieReg);

   always_comb begin
      rdata = '0;
      if (dpValid && !dpWrite) begin
         case (dpAddr)
            REG_OUT:   rdata = outReg;
            REG_DIR:   rdata = dirReg;
            REG_IN:    rdata = syncQ;
            REG_IE:    rdata = ieReg;
            REG_ITYPE: rdata = itypeReg;
            REG_IPOL:  rdata = ipolReg;
            REG_ISTAT: rdata = istatReg;
            default:   rdata = '0;
         endcase
      end
      HRDATA = 32'(rdata);
   end

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Randomised self-checking bench for ahb_gpio_irq against a behavioural model of the
// register map, pin loopback and interrupt rules.
module tb_ahb_gpio_irq;

   localparam int W  = 24;
   localparam int SS = 2;

   logic        HCLK = 0, HRESET = 0, HSEL = 0, HWRITE = 0, HREADY = 1;
   logic [7:0]  HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic [31:0] HWDATA = '0;
   wire  [31:0] HRDATA;
   wire         HREADYOUT, HRESP, irq;
   wire  [W-1:0] pins;

   logic [W-1:0] extEn = '1, extVal = '0;
   int testCount = 0, failCount = 0;

   logic [W-1:0] mOut = '0, mDir = '0, mIe = '0, mItype = '0, mIpol = '0, mIstat = '0;
   logic [W-1:0] pinHist[$];
   logic         mDpValid = 0, mDpWrite = 0;
   logic [3:0]   mDpAddr = '0;

   ahb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .pins(pins), .irq(irq)
   );

   // External pad drivers only drive pins the model sees as inputs
   for (genvar i = 0; i < W; i++) begin : gExt
      assign pins[i] = extEn[i] ? extVal[i] : 1'bz;
   end

   always #5 HCLK = ~HCLK;

   // pinHist[i] is the pad value sampled i+1 edges before the one being processed
   function automatic logic [W-1:0] histAt(int idx);
      if (idx < pinHist.size()) return pinHist[idx];
      return '0;
   endfunction

   function automatic logic [31:0] modelRead(logic [3:0] idx);
      case (idx)
         4'h0: return 32'(mOut);
         4'h1: return 32'(mDir);
         4'h2: return 32'(histAt(SS - 1));
         4'h3: return 32'(mIe);
         4'h4: return 32'(mItype);
         4'h5: return 32'(mIpol);
         4'h6: return 32'(mIstat);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [W-1:0] modelPins();
      return (mDir & mOut) | (~mDir & extVal);
   endfunction

   always @(posedge HCLK or posedge HRESET) begin : modelProc
      logic [W-1:0] s, p, evt, setB, clr, wd;
      if (HRESET) begin
         mOut = '0; mDir = '0; mIe = '0; mItype = '0; mIpol = '0; mIstat = '0;
         mDpValid = 0; mDpWrite = 0; mDpAddr = '0;
         pinHist.delete();
         extEn <= '1;
      end else begin
         s = histAt(SS - 1);
         p = histAt(SS);
         for (int i = 0; i < W; i++)
            evt[i] = (s[i] == mIpol[i]) && (!mItype[i] || s[i] != p[i]);
         setB = evt & mIe;
         wd   = HWDATA[W-1:0];
         clr  = '0;
         pinHist.push_front(modelPins());
         if (pinHist.size() > SS + 1) void'(pinHist.pop_back());
         if (mDpValid && mDpWrite) begin
            case (mDpAddr)
               4'h0: mOut   = wd;
               4'h1: mDir   = wd;
               4'h3: mIe    = wd;
               4'h4: mItype = wd;
               4'h5: mIpol  = wd;
               4'h6: clr    = wd;
`ifdef AHB_GPIO_SETCLR_EN
               4'h7: mOut   = mOut | wd;
               4'h8: mOut   = mOut & ~wd;
               4'h9: mOut   = mOut ^ wd;
`endif
               default: ;
            endcase
         end
         mIstat   = (mIstat & ~clr) | setB;
         mDpValid = HSEL && HREADY && HTRANS[1];
         mDpWrite = HWRITE;
         mDpAddr  = HADDR[5:2];
         extEn   <= ~mDir;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Continuous watch on irq and the pads, half a cycle away from the active edge
   always @(negedge HCLK) begin
      if (!HRESET) begin
         #1;
         if (!HRESET) begin
            checkOutput("irq", 32'(irq), 32'(|(mIstat & mIe)));
            checkOutput("pins", 32'(pins), 32'(modelPins()));
         end
      end
   end

   task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
      @(negedge HCLK);
      HSEL = 1; HADDR = addr; HTRANS = 2'b10; HWRITE = 1;
      @(negedge HCLK);
      HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = data;
   endtask

   task automatic busRead(input logic [7:0] addr, output logic [31:0] data);
      @(negedge HCLK);
      HSEL = 1; HADDR = addr; HTRANS = 2'b10; HWRITE = 0;
      @(negedge HCLK);
      HSEL = 0; HTRANS = 2'b00;
      data = HRDATA;
   endtask

   task automatic readCheck(input string tag, input logic [7:0] addr, output logic [31:0] data);
      busRead(addr, data);
      checkOutput(tag, data, modelRead(addr[5:2]));
   endtask

   task automatic applyStimulus();
      logic [31:0] rd;
      int op;
      logic [7:0] addr;
      op   = $urandom_range(0, 9);
      addr = {2'($urandom), 4'($urandom_range(0, 15)), 2'($urandom)};
      if (op < 4) busWrite(addr, $urandom);
      else if (op < 7) readCheck("rand_rd", addr, rd);
      else begin
         @(negedge HCLK);
         extVal = W'($urandom);
      end
   endtask

   initial begin
      logic [31:0] rd;
      #1 HRESET = 1;
      repeat (3) @(negedge HCLK);
      HRESET = 0;

      // Reset state: not driving pads, bus always ready/OKAY, all registers zero
      extVal = W'(24'h5A3C96);
      #1;
      checkOutput("rst_pins_z", 32'(pins), 32'h005A3C96);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      checkOutput("hreadyout", 32'(HREADYOUT), 32'h1);
      checkOutput("hresp", 32'(HRESP), 32'h0);
      extVal = '0;
      repeat (SS + 2) @(negedge HCLK);
      for (int a = 0; a < 16; a++) begin
         readCheck("rst_rd", 8'(a * 4), rd);
         checkOutput("rst_rd_zero", rd, 32'h0);
      end

      // Direction and output drive with loopback into IN
      busWrite(8'h04, 32'h0000_00FF);
      busWrite(8'h00, 32'hA5A5_A5A5);
      @(negedge HCLK); #1;
      checkOutput("pins_low8", 32'(pins[7:0]), 32'hA5);
      repeat (SS) @(negedge HCLK);
      readCheck("in_loop", 8'h08, rd);
      checkOutput("in_loop_val", rd, 32'h0000_00A5);

      // Rising-edge interrupt on pin 3 and its exact latency
      busWrite(8'h04, 32'h0);
      repeat (SS + 2) @(negedge HCLK);
      busWrite(8'h10, 32'h8);
      busWrite(8'h14, 32'h8);
      busWrite(8'h0C, 32'h8);
      repeat (2) @(negedge HCLK);
      @(negedge HCLK);
      extVal[3] = 1'b1;
      for (int j = 0; j < SS; j++) begin
         @(negedge HCLK); #1;
         checkOutput("edge_irq_early", 32'(irq), 32'h0);
      end
      @(negedge HCLK); #1;
      checkOutput("edge_irq_rise", 32'(irq), 32'h1);
      readCheck("edge_istat", 8'h18, rd);
      checkOutput("edge_istat_val", rd, 32'h8);
      busWrite(8'h18, 32'h8);
      @(negedge HCLK); #1;
      checkOutput("w1c_irq", 32'(irq), 32'h0);

      // Level-high interrupt on pin 5: a W1C while active loses to the set
      busWrite(8'h14, 32'h28);
      busWrite(8'h0C, 32'h28);
      @(negedge HCLK);
      extVal[5] = 1'b1;
      repeat (SS + 2) @(negedge HCLK);
      readCheck("lvl_istat", 8'h18, rd);
      checkOutput("lvl_istat_val", rd, 32'h20);
      busWrite(8'h18, 32'h20);
      readCheck("lvl_setwins", 8'h18, rd);
      checkOutput("lvl_setwins_val", rd, 32'h20);
      @(negedge HCLK);
      extVal[5] = 1'b0;
      repeat (SS + 2) @(negedge HCLK);
      busWrite(8'h18, 32'h20);
      readCheck("lvl_cleared", 8'h18, rd);
      checkOutput("lvl_cleared_val", rd, 32'h0);

      // Back-to-back write then read of OUT with zero wait states
      @(negedge HCLK);
      HSEL = 1; HADDR = 8'h00; HTRANS = 2'b10; HWRITE = 1;
      @(negedge HCLK);
      HWDATA = 32'h1; HADDR = 8'h00; HWRITE = 0;
      @(negedge HCLK);
      HSEL = 0; HTRANS = 2'b00;
      checkOutput("b2b_rd", HRDATA, 32'h1);
      checkOutput("b2b_ready", 32'(HREADYOUT), 32'h1);
      readCheck("unmapped", 8'h3C, rd);
      checkOutput("unmapped_val", rd, 32'h0);

      // Bits above WIDTH read as zero
      busWrite(8'h00, 32'hFFFF_FFFF);
      readCheck("width_mask", 8'h00, rd);
      checkOutput("width_mask_val", rd, 32'h00FF_FFFF);

      // SET/CLR/TGL aliases
      busWrite(8'h00, 32'hF0);
      busWrite(8'h1C, 32'h0F);
      busWrite(8'h20, 32'h3C);
      busWrite(8'h24, 32'hFF);
      readCheck("setclr", 8'h00, rd);
`ifdef AHB_GPIO_SETCLR_EN
      checkOutput("setclr_val", rd, 32'h3C);
`else
      checkOutput("setclr_val", rd, 32'hF0);
`endif

      // Reset asserted in the middle of a transfer
      busWrite(8'h04, 32'hFF);
      busWrite(8'h00, 32'h3C);
      @(negedge HCLK);
      HSEL = 1; HADDR = 8'h00; HTRANS = 2'b10; HWRITE = 1;
      #2 HRESET = 1;
      #1;
      checkOutput("midrst_irq", 32'(irq), 32'h0);
      checkOutput("midrst_hrdata", HRDATA, 32'h0);
      @(negedge HCLK);
      HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'hFFFF;
      extVal = W'($urandom);
      @(negedge HCLK);
      HRESET = 0;
      #1;
      checkOutput("midrst_pins_z", 32'(pins), 32'(extVal));
      extVal = '0;
      repeat (SS + 2) @(negedge HCLK);
      readCheck("midrst_out", 8'h00, rd);
      checkOutput("midrst_out_val", rd, 32'h0);
      readCheck("midrst_dir", 8'h04, rd);
      checkOutput("midrst_dir_val", rd, 32'h0);

      for (int n = 0; n < 400; n++) applyStimulus();
      repeat (2) @(negedge HCLK);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
